// File: rtl/lfsr_descrambler.sv
// Self-synchronising serial descrambler with a fill/lock FSM and a PRBS
// all-zero checker whose error counter saturates.
module lfsr_descrambler #(
    parameter logic [7:0]  P           = 8'b1101_1001,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             check_en,
    input  logic             clr_err,
    output logic             out_valid,
    output logic             out_bit,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {StFill, StLocked} state_e;

    localparam logic [3:0] LastFill  = 4'd7;
    localparam logic [3:0] LossLimit = 4'(LOSS_THRESH - 1);

    state_e           state_q, state_d;
    logic [7:0]       h_q, h_d;
    logic [3:0]       fill_q, fill_d;
    logic [3:0]       consec_q, consec_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic d;
    logic chk_err;
    logic lose_lock;

    // Taps use the history as it was before this bit shifts in.
    assign d         = in_bit ^ (^(P & h_q));
    assign chk_err   = check_en & d;
    assign lose_lock = chk_err && (consec_q == LossLimit);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            unique case (state_q)
                StFill:   if (fill_q == LastFill) state_d = StLocked;
                StLocked: if (lose_lock) state_d = StFill;
                default:  state_d = StFill;
            endcase
        end
    end

    // Datapath next-state
    always_comb begin
        h_d         = h_q;
        fill_d      = fill_q;
        consec_d    = consec_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        err_d       = err_q;
        if (in_valid) begin
            h_d = {h_q[6:0], in_bit};
            if (state_q == StFill) begin
                fill_d = (fill_q == LastFill) ? 4'd0 : fill_q + 4'd1;
            end else begin
                out_valid_d = 1'b1;
                out_bit_d   = d;
                if (chk_err) begin
                    if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                    // History is kept on loss of lock; only the fill count restarts.
                    if (lose_lock) begin
                        consec_d = 4'd0;
                        fill_d   = 4'd0;
                    end else begin
                        consec_d = consec_q + 4'd1;
                    end
                end else begin
                    consec_d = 4'd0;
                end
            end
        end
        if (clr_err) err_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            fill_q      <= '0;
            consec_q    <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            h_q         <= h_d;
            fill_q      <= fill_d;
            consec_q    <= consec_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            err_q       <= err_d;
        end
    end

    // Output logic
    always_comb begin
        locked    = (state_q == StLocked);
        out_valid = out_valid_q;
        out_bit   = out_bit_q;
        err_cnt   = err_q;
    end

endmodule

// File: tb/tb_lfsr_descrambler.sv
// Bench for lfsr_descrambler: directed steps plus random traffic, every cycle
// checked against a bit-history reference model.
module tb_lfsr_descrambler;

    localparam logic [7:0]  P_T     = 8'hD9;
    localparam int unsigned ERR_W_T = 4;
    localparam int unsigned LOSS_T  = 4;
    localparam int          ERR_MAX = (1 << ERR_W_T) - 1;

    logic               clk = 1'b0;
    logic               reset, in_valid, in_bit, check_en, clr_err;
    logic               out_valid, out_bit, locked;
    logic [ERR_W_T-1:0] err_cnt;

    lfsr_descrambler #(
        .P          (P_T),
        .ERR_W      (ERR_W_T),
        .LOSS_THRESH(LOSS_T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .check_en (check_en),
        .clr_err  (clr_err),
        .out_valid(out_valid),
        .out_bit  (out_bit),
        .locked   (locked),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: list of received bits (index 0 = newest), number of
    // accepts since the last sync loss, current error run and error total.
    bit         m_hist[$];
    int         m_cnt, m_consec, m_err;
    bit         m_ov, m_ob;
    logic [7:0] p_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_taps();
        bit t = 1'b0;
        for (int k = 0; k < 8; k++) if (p_mask[k]) t ^= m_hist[k];
        return t;
    endfunction

    task automatic model(input bit rst, input bit v, input bit b, input bit ce, input bit clr);
        bit d, was_locked;
        if (rst) begin
            m_hist = {};
            repeat (8) m_hist.push_back(1'b0);
            m_cnt = 0; m_consec = 0; m_err = 0; m_ov = 1'b0; m_ob = 1'b0;
            return;
        end
        m_ov = 1'b0;
        if (v) begin
            d          = b ^ m_taps();
            was_locked = (m_cnt >= 8);
            m_hist.push_front(b);
            void'(m_hist.pop_back());
            if (!was_locked) begin
                m_cnt++;
            end else begin
                m_ov = 1'b1;
                m_ob = d;
                if (ce && d) begin
                    if (m_err < ERR_MAX) m_err++;
                    m_consec++;
                    if (m_consec == LOSS_T) begin
                        m_cnt    = 0;
                        m_consec = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (clr) m_err = 0;
    endtask

    task automatic step(input bit rst, input bit v, input bit b, input bit ce, input bit clr);
        reset = rst; in_valid = v; in_bit = b; check_en = ce; clr_err = clr;
        @(posedge clk);
        #1;
        model(rst, v, b, ce, clr);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("out_bit", out_bit, m_ob);
        chk("locked", locked, (m_cnt >= 8));
        chk("err_cnt", err_cnt, m_err);
    endtask

    initial begin
        int         n_ov;
        int         n_acc;
        bit         b, s;
        logic [7:0] sh;
        p_mask = P_T;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_err", err_cnt, 0);

        // Fill with eight zeros: no output, lock one cycle after the 8th
        n_ov = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0);
            n_ov += int'(out_valid);
            if (i == 6) chk("not_locked_before_8th", locked, 0);
        end
        chk("fill_no_output", n_ov, 0);
        chk("locked_after_fill", locked, 1);
        step(0, 0, 0, 0, 0);
        chk("idle_no_output", out_valid, 0);

        // Locked with zero history: 1,0,0 descrambles to 1,1,0
        step(0, 1, 1, 0, 0);
        chk("seq_bit0", out_bit, 1);
        step(0, 1, 0, 0, 0);
        chk("seq_bit1", out_bit, 1);
        step(0, 1, 0, 0, 0);
        chk("seq_bit2", out_bit, 0);

        // Four consecutive check errors force loss of lock
        for (int i = 0; i < 4; i++) begin
            b = 1'b1 ^ m_taps();
            step(0, 1, b, 1, 0);
        end
        chk("loss_err_cnt", err_cnt, 4);
        chk("loss_locked", locked, 0);
        chk("loss_last_bit_valid", out_valid, 1);
        n_ov = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1'($urandom), 1, 0);
            n_ov += int'(out_valid);
        end
        chk("relock_no_output", n_ov, 0);
        chk("relock", locked, 1);

        // Drive err_cnt to all-ones without losing lock
        for (int i = 0; i < 40 && m_err < ERR_MAX; i++) begin
            step(0, 1, 1'b1 ^ m_taps(), 1, 0);
            step(0, 1, m_taps(), 1, 0);
        end
        chk("err_at_max", err_cnt, ERR_MAX);
        step(0, 1, 1'b1 ^ m_taps(), 1, 0);
        chk("err_saturates", err_cnt, ERR_MAX);
        step(0, 1, m_taps(), 1, 0);
        step(0, 1, 1'b1 ^ m_taps(), 1, 1);
        chk("clr_beats_increment", err_cnt, 0);
        chk("clr_keeps_lock", locked, 1);

        // Random traffic, including gaps, clears, check toggling and resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Mid-stream reset while locked with in_valid high
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        chk("pre_reset_locked", locked, 1);
        step(1, 1, 1, 1, 0);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_locked", locked, 0);
        n_ov = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1'($urandom), 1, 0);
            n_ov += int'(out_valid);
        end
        chk("post_reset_no_output", n_ov, 0);
        chk("post_reset_locked", locked, 1);

        // Matching scrambler, seed 0x01, all-zero source, random gaps
        step(1, 0, 0, 0, 0);
        sh    = 8'h01;
        n_ov  = 0;
        n_acc = 0;
        for (int i = 0; i < 5000 && n_acc < 512; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(0, 0, 1'($urandom), 1, 0);
            end else begin
                s  = ^(p_mask & sh);
                sh = {sh[6:0], s};
                step(0, 1, s, 1, 0);
                n_acc++;
                if (out_valid) chk("scr_zero", out_bit, 0);
            end
            n_ov += int'(out_valid);
        end
        chk("scr_accepts", n_acc, 512);
        chk("scr_out_count", n_ov, 504);
        chk("scr_err_cnt", err_cnt, 0);
        chk("scr_locked", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
